// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    function automatic int word_sel_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Byte offset within a line: word select plus the two ignored byte bits.
    function automatic int offset_width(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int line_bits(input int words_per_line);
        return WORD_W * words_per_line;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage with one read port, a word-write port and a line-fill port.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24
) (
    input  logic                                  clk,
    input  logic                                  rst_n_i,
    input  logic [index_width(NUM_SETS)-1:0]      index_i,
    output logic [TAG_W-1:0]                      rd_tag_o,
    output logic                                  rd_valid_o,
    output logic                                  rd_dirty_o,
    output logic [line_bits(WORDS_PER_LINE)-1:0]  rd_line_o,
    input  logic                                  wr_en_i,
    input  logic [word_sel_width(WORDS_PER_LINE)-1:0] wr_sel_i,
    input  logic [WORD_W-1:0]                     wr_word_i,
    input  logic                                  fill_en_i,
    input  logic [TAG_W-1:0]                      fill_tag_i,
    input  logic [line_bits(WORDS_PER_LINE)-1:0]  fill_line_i,
    input  logic                                  clean_en_i
);
    localparam int WSEL_W    = word_sel_width(WORDS_PER_LINE);
    localparam int LINE_BITS = line_bits(WORDS_PER_LINE);

    logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0] data_mem [NUM_SETS];
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [LINE_BITS-1:0] merged_line;

    // Hits must answer in the request cycle, so the read port is combinational.
    assign rd_tag_o   = tag_mem[index_i];
    assign rd_line_o  = data_mem[index_i];
    assign rd_valid_o = valid_q[index_i];
    assign rd_dirty_o = dirty_q[index_i];

    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_merge
            assign merged_line[gi*WORD_W +: WORD_W] =
                (wr_sel_i == WSEL_W'(gi)) ? wr_word_i : rd_line_o[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            data_mem[index_i] <= fill_line_i;
            tag_mem[index_i]  <= fill_tag_i;
        end else if (wr_en_i) begin
            data_mem[index_i] <= merged_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[index_i] <= 1'b1;
        end else if (clean_en_i) begin
            dirty_q[index_i] <= 1'b0;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Blocking direct-mapped write-back/write-allocate data cache with hit/miss counters.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 is_input_valid,
    input  logic [ADDR_W-1:0]                    addr,
    input  logic                                 mem_rw,
    input  logic [WORD_W-1:0]                    din,
    output logic                                 is_ready,
    output logic                                 is_output_valid,
    output logic [WORD_W-1:0]                    dout,
    output logic                                 is_hit,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [line_bits(WORDS_PER_LINE)-1:0] mem_wdata,
    input  logic                                 mem_ack,
    input  logic [line_bits(WORDS_PER_LINE)-1:0] mem_rdata,
    output logic [31:0]                          hit_count,
    output logic [31:0]                          miss_count
);
    localparam int WSEL_W    = word_sel_width(WORDS_PER_LINE);
    localparam int OFFSET_W  = offset_width(WORDS_PER_LINE);
    localparam int INDEX_W   = index_width(NUM_SETS);
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_BITS = line_bits(WORDS_PER_LINE);

    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [WSEL_W-1:0]    word_sel;
    logic                 unused_byte_bits;

    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [LINE_BITS-1:0] rd_line;
    logic [WORD_W-1:0]    rd_word;

    state_e               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [31:0]          hit_count_q, miss_count_q;

    logic                 hit, miss, fill_en, clean_en;

    assign req_index        = addr[OFFSET_W +: INDEX_W];
    assign req_tag          = addr[ADDR_W-1 -: TAG_W];
    assign word_sel         = addr[2 +: WSEL_W];
    assign unused_byte_bits = ^addr[1:0];

    dcache_line_array #(
        .NUM_SETS       (NUM_SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_lines (
        .clk         (clk),
        .rst_n_i     (reset),
        .index_i     (req_index),
        .rd_tag_o    (rd_tag),
        .rd_valid_o  (rd_valid),
        .rd_dirty_o  (rd_dirty),
        .rd_line_o   (rd_line),
        .wr_en_i     (hit && mem_rw),
        .wr_sel_i    (word_sel),
        .wr_word_i   (din),
        .fill_en_i   (fill_en),
        .fill_tag_i  (req_tag),
        .fill_line_i (mem_rdata),
        .clean_en_i  (clean_en)
    );

    assign rd_word = rd_line[word_sel*WORD_W +: WORD_W];

    assign is_ready        = (state_q == ST_IDLE);
    assign hit             = is_ready && is_input_valid && rd_valid && (rd_tag == req_tag);
    assign miss            = is_ready && is_input_valid && !hit;
    assign is_hit          = hit;
    assign is_output_valid = hit;
    assign dout            = (hit && !mem_rw) ? rd_word : '0;

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Each memory state spends one cycle launching the request; acks only count once it is up.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_en     = 1'b0;
        clean_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = MEM_WRITE;
                    mem_addr_d  = {rd_tag, req_index, {OFFSET_W{1'b0}}};
                    mem_wdata_d = rd_line;
                end else if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = MEM_READ;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    clean_en    = 1'b1;
                    state_d     = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = MEM_READ;
                    mem_addr_d  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                    mem_wdata_d = '0;
                end else if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_addr_d  = '0;
                    fill_en     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

endmodule
